// File: rtl/complex_mult_sequencer_if.sv
// Operand/result handshake bundle for complex_mult_sequencer.
// master: operand source and result consumer side; slave: the sequencer.
interface complex_mult_sequencer_if;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] In_Op1;
    logic [15:0] In_Op2;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [33:0] Out_Data;

    modport master (
        output In_Valid,
        output In_Op1,
        output In_Op2,
        output Out_Ready,
        input  In_Ready,
        input  Out_Valid,
        input  Out_Data
    );

    modport slave (
        input  In_Valid,
        input  In_Op1,
        input  In_Op2,
        input  Out_Ready,
        output In_Ready,
        output Out_Valid,
        output Out_Data
    );
endinterface

// File: rtl/complex_mult_sequencer.sv
// Time-multiplexed complex multiplier: one shared 8x8 signed multiplier is
// stepped through ac, bd, ad, bc and the partial products are accumulated
// into 16-bit wrapping real/imag sums. Result packed as
// {Real[15], Real, Imag[15], Imag}.
// Optional macro CMPLX_SEQ_CONJ_EN adds In_Conj (latched at accept); when set
// the block computes op1 * conj(op2).
//
// state | meaning
// IDLE  | waiting for an operand pair
// AC    | multiply a*c, Real += p
// BD    | multiply b*d, Real -= p (conj: Real += p)
// AD    | multiply a*d, Imag += p (conj: Imag -= p)
// BC    | multiply b*c, Imag += p, load result
// OUT   | result presented, waiting for Out_Ready
module complex_mult_sequencer (
    input  logic                     Clk,
    input  logic                     Reset,
    complex_mult_sequencer_if.slave  bus,
`ifdef CMPLX_SEQ_CONJ_EN
    input  logic                     In_Conj,
`endif
    output logic                     Busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AC   = 3'd1,
        BD   = 3'd2,
        AD   = 3'd3,
        BC   = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic               accept;
    logic               in_ready;
    logic signed [7:0]  mul_x;
    logic signed [7:0]  mul_y;
    logic signed [15:0] product;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  op_c;
    logic [7:0]  op_d;
    logic        conj_q;
    logic [15:0] real_acc;
    logic [15:0] imag_acc;
    logic [15:0] real_next;
    logic [15:0] imag_next;

    logic        out_valid;
    logic [33:0] out_data;
    logic        busy_q;

    // Both operands are sign-extended to 16 bits so the low half of the
    // product is the exact signed 8x8 result.
    assign product = 16'(mul_x) * 16'(mul_y);

    // State register; reset overrides accept and handoff.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: fixed four-step product sequence, OUT waits on the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = AC;
            AC:   state_next = BD;
            BD:   state_next = AD;
            AD:   state_next = BC;
            BC:   state_next = OUT;
            OUT:  if (bus.Out_Ready) state_next = bus.In_Valid ? AC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: input-side ready and multiplier operand select.
    always_comb begin
        in_ready = (state == IDLE) || ((state == OUT) && bus.Out_Ready);
        accept   = bus.In_Valid && in_ready;
        mul_x    = '0;
        mul_y    = '0;
        case (state)
            AC: begin mul_x = op_a; mul_y = op_c; end
            BD: begin mul_x = op_b; mul_y = op_d; end
            AD: begin mul_x = op_a; mul_y = op_d; end
            BC: begin mul_x = op_b; mul_y = op_c; end
            default: begin mul_x = '0; mul_y = '0; end
        endcase
    end

    // Accumulator update for the current step; accept clears for a new pair.
    always_comb begin
        real_next = real_acc;
        imag_next = imag_acc;
        if (accept) begin
            real_next = '0;
            imag_next = '0;
        end else begin
            case (state)
                AC: real_next = real_acc + product;
                BD: real_next = conj_q ? (real_acc + product) : (real_acc - product);
                AD: imag_next = conj_q ? (imag_acc - product) : (imag_acc + product);
                BC: imag_next = imag_acc + product;
                default: ;
            endcase
        end
    end

    // Operand capture at accept and accumulator registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            op_d     <= '0;
            real_acc <= '0;
            imag_acc <= '0;
        end else begin
            if (accept) begin
                op_a <= bus.In_Op1[15:8];
                op_b <= bus.In_Op1[7:0];
                op_c <= bus.In_Op2[15:8];
                op_d <= bus.In_Op2[7:0];
            end
            real_acc <= real_next;
            imag_acc <= imag_next;
        end
    end

`ifdef CMPLX_SEQ_CONJ_EN
    // Conjugate select is held for the whole transaction.
    always_ff @(posedge Clk) begin
        if (Reset)       conj_q <= 1'b0;
        else if (accept) conj_q <= In_Conj;
    end
`else
    assign conj_q = 1'b0;
`endif

    // Registered outputs: result loads on leaving BC and is held after handoff.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            busy_q    <= 1'b0;
        end else begin
            out_valid <= (state_next == OUT);
            busy_q    <= (state_next != IDLE);
            if (state == BC)
                out_data <= {real_next[15], real_next, imag_next[15], imag_next};
        end
    end

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid;
    assign bus.Out_Data  = out_data;
    assign Busy          = busy_q;

endmodule
